// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - shared RAM port sequencer with MSI snoop control for two cores
// Optional ARB_RR_EN: round-robin tie-break between cores; otherwise core0 always wins ties.
module coherence_bus_ctrl #(
   parameter int CPUS = 2,
   parameter int AW   = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [CPUS-1:0]         iREN,
   input  logic [CPUS-1:0][AW-1:0] iaddr,
   output logic [CPUS-1:0]         iwait,
   output logic [CPUS-1:0][AW-1:0] iload,
   input  logic [CPUS-1:0]         dREN,
   input  logic [CPUS-1:0]         dWEN,
   input  logic [CPUS-1:0][AW-1:0] daddr,
   input  logic [CPUS-1:0][AW-1:0] dstore,
   output logic [CPUS-1:0]         dwait,
   output logic [CPUS-1:0][AW-1:0] dload,
   input  logic [CPUS-1:0]         cctrans,
   input  logic [CPUS-1:0]         ccwrite,
   output logic [CPUS-1:0]         ccwait,
   output logic [CPUS-1:0]         ccinv,
   output logic [CPUS-1:0][AW-1:0] ccsnoopaddr,
   output logic                    ramREN,
   output logic                    ramWEN,
   output logic [AW-1:0]           ramaddr,
   output logic [AW-1:0]           ramstore,
   input  logic [AW-1:0]           ramload,
   input  logic                    ramready
);

   typedef enum logic [2:0] {
      S_IDLE, S_WB, S_SNOOP, S_RESP, S_MEM, S_C2C, S_IFETCH
   } state_t;

   state_t state_q, state_d;
   logic   req_q, req_d;
   logic   word_q, word_d;
   logic   resp_q, resp_d;
   logic   oth;
   logic   abort;
   logic   tie_pick;
   logic   win;
   logic [CPUS-1:0] wb_v, coh_v, sel_v;

   assign oth   = ~req_q;
   assign abort = ~(dREN[req_q] & cctrans[req_q]);

   // Flush writes (dWEN with cctrans) ride the plain writeback path.
   assign wb_v  = dWEN;
   assign coh_v = cctrans & dREN & ~dWEN;
   assign sel_v = (|wb_v) ? wb_v : ((|coh_v) ? coh_v : iREN);

`ifdef ARB_RR_EN
   logic last_q, last_d;
   assign tie_pick = ~last_q;
`else
   assign tie_pick = 1'b0;
`endif

   assign win = (sel_v == 2'b11) ? tie_pick : sel_v[1];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         word_q  <= 1'b0;
         resp_q  <= 1'b0;
`ifdef ARB_RR_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         word_q  <= word_d;
         resp_q  <= resp_d;
`ifdef ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      word_d  = word_q;
      resp_d  = resp_q;
`ifdef ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            word_d = 1'b0;
            resp_d = 1'b0;
            if (|sel_v) begin
               req_d = win;
`ifdef ARB_RR_EN
               last_d = win;
`endif
               if (|wb_v)       state_d = S_WB;
               else if (|coh_v) state_d = S_SNOOP;
               else             state_d = S_IFETCH;
            end
         end
         S_WB, S_IFETCH: if (ramready) state_d = S_IDLE;
         S_SNOOP: state_d = S_RESP;
         // The snooped cache needs one cycle to match before its dirty flag is valid.
         S_RESP: begin
            if (!resp_q) resp_d  = 1'b1;
            else         state_d = ccwrite[oth] ? S_C2C : S_MEM;
         end
         S_MEM: begin
            if (abort) state_d = S_IDLE;
            else if (ramready) begin
               word_d = 1'b1;
               if (word_q) state_d = S_IDLE;
            end
         end
         S_C2C: begin
            if (ramready) begin
               word_d = 1'b1;
               if (word_q) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      iwait       = '1;
      iload       = '0;
      dwait       = '1;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      if (!RST) begin
         case (state_q)
            S_WB: begin
               ramWEN       = 1'b1;
               ramaddr      = daddr[req_q];
               ramstore     = dstore[req_q];
               dwait[req_q] = ~ramready;
            end
            S_SNOOP, S_RESP: begin
               ccwait[oth]      = 1'b1;
               ccsnoopaddr[oth] = daddr[req_q];
               ccinv[oth]       = ccwrite[req_q];
            end
            S_MEM: begin
               ccwait[oth]      = 1'b1;
               ccsnoopaddr[oth] = daddr[req_q];
               if (!abort) begin
                  ramREN       = 1'b1;
                  ramaddr      = daddr[req_q];
                  dload[req_q] = ramload;
                  dwait[req_q] = ~ramready;
               end
            end
            S_C2C: begin
               ccwait[oth]      = 1'b1;
               ccsnoopaddr[oth] = daddr[req_q];
               ramWEN           = 1'b1;
               ramaddr          = daddr[oth];
               ramstore         = dstore[oth];
               dload[req_q]     = dstore[oth];
               dwait[req_q]     = ~ramready;
               dwait[oth]       = ~ramready;
            end
            S_IFETCH: begin
               ramREN       = 1'b1;
               ramaddr      = iaddr[req_q];
               iload[req_q] = ramload;
               iwait[req_q] = ~ramready;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - scoreboard bench for coherence_bus_ctrl with a transaction-level model
module tb_coherence_bus_ctrl;

   logic CLK = 1'b0;
   logic RST;
   logic [1:0] iREN, dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0] iaddr, daddr, dstore;
   logic [1:0] iwait, dwait, ccwait, ccinv;
   logic [1:0][31:0] iload, dload, ccsnoopaddr;
   logic ramREN, ramWEN, ramready;
   logic [31:0] ramaddr, ramstore, ramload;

   always #5 CLK = ~CLK;

   coherence_bus_ctrl #(.CPUS(2), .AW(32)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready)
   );

   function automatic logic [31:0] ram_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign ramload = ram_fn(ramaddr);

   typedef struct packed {
      logic             wr;
      logic [31:0]      addr;
      logic [31:0]      wd;
      logic [1:0]       dw;
      logic [1:0]       iw;
      logic [1:0][31:0] dl;
      logic [1:0][31:0] il;
   } exp_t;

   typedef struct packed {
      logic        o;
      logic [31:0] a;
      logic        inv;
   } snp_t;

   exp_t cq[$];
   snp_t snq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   last_served = 1;
   bit   stall_ram = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RAM: random latency, answers only while a strobe is up
   initial begin
      ramready = 1'b0;
      forever begin
         @(posedge CLK);
         #2;
         ramready = (ramREN | ramWEN) && !stall_ram && ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: pops the scoreboard on every completed RAM word and every new snoop
   initial begin
      logic [1:0] ccw_prev;
      exp_t e;
      snp_t s;
      ccw_prev = 2'b00;
      forever begin
         @(negedge CLK);
         chk("one_strobe", {63'd0, ramREN & ramWEN}, 64'd0);
         if (!RST && ccwait != 2'b00 && ccw_prev == 2'b00) begin
            chk("snoop_pending", {63'd0, snq.size() > 0}, 64'd1);
            if (snq.size() > 0) begin
               s = snq.pop_front();
               chk("snoop_core", {62'd0, ccwait}, {62'd0, 2'b01 << s.o});
               chk("snoop_addr", {32'd0, ccsnoopaddr[s.o]}, {32'd0, s.a});
               chk("snoop_inv", {62'd0, ccinv}, s.inv ? {62'd0, 2'b01 << s.o} : 64'd0);
            end
         end
         ccw_prev = ccwait;
         if (ramREN | ramWEN) begin
            if (ramready && !RST) begin
               chk("completion_pending", {63'd0, cq.size() > 0}, 64'd1);
               if (cq.size() > 0) begin
                  e = cq.pop_front();
                  chk("ram_wen", {63'd0, ramWEN}, {63'd0, e.wr});
                  chk("ram_addr", {32'd0, ramaddr}, {32'd0, e.addr});
                  if (e.wr) chk("ram_store", {32'd0, ramstore}, {32'd0, e.wd});
                  chk("waits", {60'd0, dwait, iwait}, {60'd0, ~e.dw, ~e.iw});
                  chk("dload", dload, e.dl);
                  chk("iload", iload, e.il);
               end
            end else begin
               chk("busy_waits", {60'd0, dwait, iwait}, 64'hF);
            end
         end else begin
            chk("idle_waits", {60'd0, dwait, iwait}, 64'hF);
            chk("idle_loads", {63'd0, |{dload, iload}}, 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int tie_winner();
`ifdef ARB_RR_EN
      return (last_served == 1) ? 0 : 1;
`else
      return 0;
`endif
   endfunction

   task automatic exp_ifetch(input int c, input logic [31:0] a);
      exp_t e;
      e = '0;
      e.addr = a;
      e.iw[c] = 1'b1;
      e.il[c] = ram_fn(a);
      cq.push_back(e);
      last_served = c;
   endtask

   task automatic exp_wb(input int c, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e = '0;
      e.wr = 1'b1;
      e.addr = a;
      e.wd = d;
      e.dw[c] = 1'b1;
      cq.push_back(e);
      last_served = c;
   endtask

   // Coherent read/RFO: one snoop of the other core, then two words from RAM or from the dirty peer
   task automatic exp_coh(input int r, input logic [31:0] a, input bit w, input bit dirty,
                          input logic [31:0] d0, input logic [31:0] d1);
      exp_t e;
      snp_t s;
      s.o = (r == 0);
      s.a = a;
      s.inv = w;
      snq.push_back(s);
      for (int k = 0; k < 2; k++) begin
         e = '0;
         e.addr = a | ((k == 1) ? 32'h4 : 32'h0);
         if (dirty) begin
            e.wr = 1'b1;
            e.wd = (k == 1) ? d1 : d0;
            e.dw = 2'b11;
            e.dl[r] = e.wd;
         end else begin
            e.dw[r] = 1'b1;
            e.dl[r] = ram_fn(e.addr);
         end
         cq.push_back(e);
      end
      last_served = r;
   endtask

   task automatic wait_for(input int kind, input int c, input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         @(negedge CLK);
         case (kind)
            0:       seen = !dwait[c];
            1:       seen = !iwait[c];
            2:       seen = ccwait[c];
            default: seen = ramWEN;
         endcase
      end
      chk(name, {63'd0, seen}, 64'd1);
   endtask

   task automatic clr_inputs();
      iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr = '0; daddr = '0; dstore = '0;
   endtask

   task automatic drv_ifetch(input int c, input logic [31:0] a);
      @(posedge CLK); #1;
      iREN[c] = 1'b1;
      iaddr[c] = a;
      wait_for(1, c, "ifetch_done");
      @(posedge CLK); #1;
      iREN[c] = 1'b0;
   endtask

   task automatic drv_wb(input int c, input logic [31:0] a, input logic [31:0] d);
      @(posedge CLK); #1;
      dWEN[c] = 1'b1;
      daddr[c] = a;
      dstore[c] = d;
      wait_for(0, c, "wb_done");
      @(posedge CLK); #1;
      dWEN[c] = 1'b0;
   endtask

   task automatic drv_coh(input int r, input logic [31:0] a, input bit w, input bit dirty,
                          input logic [31:0] d0, input logic [31:0] d1, input bit both);
      int o;
      o = 1 - r;
      @(posedge CLK); #1;
      dREN[r] = 1'b1; cctrans[r] = 1'b1; ccwrite[r] = w; daddr[r] = a;
      ccwrite[o] = dirty;
      if (both) begin
         dREN[o] = 1'b1; cctrans[o] = 1'b1; daddr[o] = a;
      end
      @(posedge CLK); #1;
      if (both) begin
         dREN[o] = 1'b0; cctrans[o] = 1'b0;
      end
      wait_for(2, o, "snoop_seen");
      @(posedge CLK); #1;
      if (dirty) begin
         dWEN[o] = 1'b1; daddr[o] = a; dstore[o] = d0;
      end
      wait_for(0, r, "coh_word0");
      @(posedge CLK); #1;
      daddr[r] = a | 32'h4;
      if (dirty) begin
         daddr[o] = a | 32'h4; dstore[o] = d1;
      end
      wait_for(0, r, "coh_word1");
      @(posedge CLK); #1;
      dREN[r] = 1'b0; cctrans[r] = 1'b0; ccwrite = '0; dWEN[o] = 1'b0;
      @(negedge CLK);
      chk("ccwait_release", {62'd0, ccwait}, 64'd0);
   endtask

   initial begin
      int w;
      logic [31:0] a, d0, d1;
      snp_t s;
      clr_inputs();
      RST = 1'b1;
      iREN[0] = 1'b1;
      iaddr[0] = 32'h40;
      repeat (2) begin
         @(negedge CLK);
         chk("rst_iwait", {63'd0, iwait[0]}, 64'd1);
         chk("rst_ramren", {63'd0, ramREN}, 64'd0);
         chk("rst_cc", {60'd0, ccwait, ccinv}, 64'd0);
         chk("rst_snaddr", ccsnoopaddr, 64'd0);
      end
      exp_ifetch(0, 32'h40);
      @(posedge CLK); #1;
      RST = 1'b0;
      wait_for(1, 0, "t1_fetch");
      @(posedge CLK); #1;
      iREN[0] = 1'b0;

      exp_coh(0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
      drv_coh(0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      exp_coh(0, 32'h200, 1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002);
      drv_coh(0, 32'h200, 1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0);

      exp_wb(1, 32'h300, 32'h3333_3333);
      exp_ifetch(0, 32'h80);
      fork
         drv_wb(1, 32'h300, 32'h3333_3333);
         drv_ifetch(0, 32'h80);
      join

      // Reset in the first C2C word: the transfer is dropped without a completion
      stall_ram = 1'b1;
      s.o = 1'b1; s.a = 32'h600; s.inv = 1'b1;
      snq.push_back(s);
      @(posedge CLK); #1;
      dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h600; ccwrite[1] = 1'b1;
      wait_for(2, 1, "t6_snoop");
      @(posedge CLK); #1;
      dWEN[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'hC0DE;
      wait_for(3, 0, "t6_c2c");
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("t6_rst_waits", {60'd0, dwait, iwait}, 64'hF);
      chk("t6_rst_strobes", {62'd0, ramREN, ramWEN}, 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      clr_inputs();
      stall_ram = 1'b0;
      last_served = 1;
      @(negedge CLK);
      chk("t6_idle_strobes", {62'd0, ramREN, ramWEN}, 64'd0);
      chk("t6_idle_cc", {60'd0, ccwait, ccinv}, 64'd0);
      chk("t6_idle_snaddr", ccsnoopaddr, 64'd0);
      chk("t6_idle_waits", {60'd0, dwait, iwait}, 64'hF);

      for (int k = 0; k < 3; k++) begin
         w = tie_winner();
         exp_coh(w, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0);
         drv_coh(w, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      end

      for (int k = 0; k < 40; k++) begin
         int t, c;
         t = $urandom_range(0, 3);
         c = $urandom_range(0, 1);
         a = $urandom & 32'hFFFF_FFF8;
         d0 = $urandom;
         d1 = $urandom;
         case (t)
            0: begin exp_ifetch(c, a); drv_ifetch(c, a); end
            1: begin exp_wb(c, a, d0); drv_wb(c, a, d0); end
            2: begin
               exp_coh(c, a, $urandom_range(0, 1) == 1, 1'b0, d0, d1);
               drv_coh(c, a, snq[snq.size()-1].inv, 1'b0, d0, d1, 1'b0);
            end
            default: begin
               exp_coh(c, a, 1'b1, 1'b1, d0, d1);
               drv_coh(c, a, 1'b1, 1'b1, d0, d1, 1'b0);
            end
         endcase
         repeat ($urandom_range(0, 2)) @(posedge CLK);
      end

      repeat (5) @(posedge CLK);
      chk("sb_drained", cq.size() + snq.size(), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
